serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial ripple adder. An accepted start captures a and b. The adder then
//   processes one bit per cycle, LSB first, for WIDTH cycles. When the last bit
//   is done it loads sum/cout and pulses done for one cycle.
//
// Ports
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : begin an addition (accepted in IDLE or DONE only)
//   a, b  : operands, captured on an accepted start
//   busy  : high while bits are being processed (RUN)
//   done  : one-cycle pulse when sum/cout carry a new result
//   sum   : registered (a+b) mod 2^WIDTH
//   cout  : registered carry out of bit WIDTH-1
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic             carry;
  logic [CNT_W-1:0] bit_cnt;
  logic             s_bit;
  logic             c_nxt;
  logic             last_bit;
  logic             accept;

  function automatic logic majority(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Full adder on the current LSBs.
  assign s_bit    = a_sr[0] ^ b_sr[0] ^ carry;
  assign c_nxt    = majority(a_sr[0], b_sr[0], carry);
  assign res_nxt  = {s_bit, res_sr[WIDTH-1:1]};
  assign last_bit = (bit_cnt == LAST_BIT);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end
      end
      RUN: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done are registered copies of the next state so they line up with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      carry   <= 1'b0;
      bit_cnt <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
      if (accept) begin
        a_sr    <= a;
        b_sr    <= b;
        carry   <= 1'b0;
        bit_cnt <= '0;
      end else if (state == RUN) begin
        a_sr    <= a_sr >> 1;
        b_sr    <= b_sr >> 1;
        res_sr  <= res_nxt;
        carry   <= c_nxt;
        bit_cnt <= bit_cnt + 1'b1;
        // Result is published together with the final shift, not a cycle later.
        if (last_bit) begin
          sum  <= res_nxt;
          cout <= c_nxt;
        end
      end
    end
  end

endmodule
